// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: channel FSM states, channel indices and
// default timing constants.
package button_conditioner_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPress,
    StHeld,
    StRepeat,
    StWaitRelease
  } btn_state_e;

  localparam int NumCh       = 4;
  localparam int ChArriba    = 0;
  localparam int ChAbajo     = 1;
  localparam int ChIzquierda = 2;
  localparam int ChDerecha   = 3;

  localparam int unsigned DefDebounceCycles = 1_000_000;
  localparam int unsigned DefRepeatDelay    = 50_000_000;
  localparam int unsigned DefRepeatRate     = 15_000_000;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side levels and command-side pulses of the button conditioner.
interface button_conditioner_if;
  logic       btn_arriba;
  logic       btn_abajo;
  logic       btn_izquierda;
  logic       btn_derecha;
  logic       habilitar;
  logic       push_arriba;
  logic       push_abajo;
  logic       push_izquierda;
  logic       push_derecha;
  logic [3:0] held;

  modport master (
    output btn_arriba, btn_abajo, btn_izquierda, btn_derecha, habilitar,
    input  push_arriba, push_abajo, push_izquierda, push_derecha, held
  );

  modport slave (
    input  btn_arriba, btn_abajo, btn_izquierda, btn_derecha, habilitar,
    output push_arriba, push_abajo, push_izquierda, push_derecha, held
  );
endinterface

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, debounce/auto-repeat FSM and its shared counter.
// fire_o is a one-cycle strobe decoded from registered state only.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_RATE     = DefRepeatRate,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic fire_o,
  output logic held_o
);

  localparam int unsigned CntW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE));
  localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] RelLast   = CntW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_err
    $error("button_channel: timing parameters must be at least 2");
  end

  logic            sync1_q, sync2_q;
  btn_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // The low sample that leaves HELD/REPEAT counts as the first of the release run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sync2_q) begin
          state_d = StWaitPress;
          cnt_d   = '0;
        end
      end
      StWaitPress: begin
        if (!sync2_q) begin
          state_d = StIdle;
        end else if (cnt_q >= DebLast) begin
          state_d = StHeld;
          cnt_d   = '0;
          fire_o  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHeld: begin
        if (!sync2_q) begin
          state_d = StWaitRelease;
          cnt_d   = '0;
        end else if (REPEAT_EN && cnt_q >= DelayLast) begin
          state_d = StRepeat;
          cnt_d   = '0;
          fire_o  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRepeat: begin
        if (!sync2_q) begin
          state_d = StWaitRelease;
          cnt_d   = '0;
        end else if (cnt_q >= RateLast) begin
          cnt_d  = '0;
          fire_o = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitRelease: begin
        if (sync2_q) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q >= RelLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign held_o = (state_q == StHeld) || (state_q == StRepeat) || (state_q == StWaitRelease);

endmodule

// File: rtl/button_conditioner.sv
// Four debounced button channels with opposing-direction conflict suppression and a global
// enable; command pulses are re-registered so no input reaches an output combinationally.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_RATE     = DefRepeatRate
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  logic [NumCh-1:0] btn_raw, fire, held, push_d, push_q;

  assign btn_raw = {bus.btn_derecha, bus.btn_izquierda, bus.btn_abajo, bus.btn_arriba};

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (i == ChArriba || i == ChAbajo)
    ) u_channel (
      .clk   (clk),
      .reset (reset),
      .btn_i (btn_raw[i]),
      .fire_o(fire[i]),
      .held_o(held[i])
    );
  end

  // Simultaneous opposing commands cancel each other; dropped pulses are not queued.
  always_comb begin
    push_d = '0;
    push_d[ChArriba]    = bus.habilitar & fire[ChArriba] & ~fire[ChAbajo];
    push_d[ChAbajo]     = bus.habilitar & fire[ChAbajo] & ~fire[ChArriba];
    push_d[ChIzquierda] = bus.habilitar & fire[ChIzquierda] & ~fire[ChDerecha];
    push_d[ChDerecha]   = bus.habilitar & fire[ChDerecha] & ~fire[ChIzquierda];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q <= '0;
    end else begin
      push_q <= push_d;
    end
  end

  assign bus.push_arriba    = push_q[ChArriba];
  assign bus.push_abajo     = push_q[ChAbajo];
  assign bus.push_izquierda = push_q[ChIzquierda];
  assign bus.push_derecha   = push_q[ChDerecha];
  assign bus.held           = held;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=8.
module tb_button_conditioner;

  typedef struct {
    bit         new_run;
    int         n;
    logic [3:0] btn;
    logic       hab;
    logic [3:0] push;
    logic [3:0] held;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  vec_t vecs[$];

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (16),
    .REPEAT_RATE    (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] get_push();
    return {bus.push_derecha, bus.push_izquierda, bus.push_abajo, bus.push_arriba};
  endfunction

  task automatic set_in(input logic [3:0] b, input logic h);
    bus.btn_arriba    = b[0];
    bus.btn_abajo     = b[1];
    bus.btn_izquierda = b[2];
    bus.btn_derecha   = b[3];
    bus.habilitar     = h;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with all buttons low; cycle 0 is the first edge after release.
  task automatic do_reset(input logic [3:0] b, input logic h);
    set_in(b, h);
    reset = 1'b1;
    #1;
    check("push_in_reset", get_push(), 4'b0000);
    check("held_in_reset", bus.held, 4'b0000);
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic add(input bit nr, input int n, input logic [3:0] b, input logic h,
                     input logic [3:0] p, input logic [3:0] hd);
    vec_t v;
    v.new_run = nr;
    v.n       = n;
    v.btn     = b;
    v.hab     = h;
    v.push    = p;
    v.held    = hd;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    set_in(4'b0000, 1'b1);

    // Arriba held 40 cycles: pulses 6, 22, 30, 38, then release to IDLE at 45.
    add(1, 6, 4'b0001, 1, 4'b0000, 4'b0000);
    add(0, 1, 4'b0001, 1, 4'b0001, 4'b0001);
    add(0, 15, 4'b0001, 1, 4'b0000, 4'b0001);
    add(0, 1, 4'b0001, 1, 4'b0001, 4'b0001);
    add(0, 7, 4'b0001, 1, 4'b0000, 4'b0001);
    add(0, 1, 4'b0001, 1, 4'b0001, 4'b0001);
    add(0, 7, 4'b0001, 1, 4'b0000, 4'b0001);
    add(0, 1, 4'b0001, 1, 4'b0001, 4'b0001);
    add(0, 1, 4'b0001, 1, 4'b0000, 4'b0001);
    add(0, 5, 4'b0000, 1, 4'b0000, 4'b0001);
    add(0, 5, 4'b0000, 1, 4'b0000, 4'b0000);
    // Derecha short bounce, then a real press: single pulse at 16, never repeats.
    add(1, 3, 4'b1000, 1, 4'b0000, 4'b0000);
    add(0, 7, 4'b0000, 1, 4'b0000, 4'b0000);
    add(0, 6, 4'b1000, 1, 4'b0000, 4'b0000);
    add(0, 1, 4'b1000, 1, 4'b1000, 4'b1000);
    add(0, 25, 4'b1000, 1, 4'b0000, 4'b1000);
    // Arriba+abajo together: every pulse cancelled, both held.
    add(1, 6, 4'b0011, 1, 4'b0000, 4'b0000);
    add(0, 25, 4'b0011, 1, 4'b0000, 4'b0011);
    // Abajo with habilitar low until 29: only the repeat at 30 appears.
    add(1, 6, 4'b0010, 0, 4'b0000, 4'b0000);
    add(0, 23, 4'b0010, 0, 4'b0000, 4'b0010);
    add(0, 1, 4'b0010, 1, 4'b0000, 4'b0010);
    add(0, 1, 4'b0000, 1, 4'b0010, 4'b0010);
    add(0, 4, 4'b0000, 1, 4'b0000, 4'b0010);
    add(0, 3, 4'b0000, 1, 4'b0000, 4'b0000);

    foreach (vecs[k]) begin
      if (vecs[k].new_run) do_reset(4'b0000, vecs[k].hab);
      for (int j = 0; j < vecs[k].n; j++) begin
        set_in(vecs[k].btn, vecs[k].hab);
        step();
        check("table_push", get_push(), vecs[k].push);
        check("table_held", bus.held, vecs[k].held);
        cyc++;
      end
    end

    // Izquierda release with a 2-cycle glitch inside WAIT_RELEASE.
    do_reset(4'b0000, 1'b1);
    for (int c = 0; c < 26; c++) begin
      set_in({1'b0, (c < 10 || c == 13 || c == 14), 2'b00}, 1'b1);
      step();
      check("glitch_push", get_push(), (c == 6) ? 4'b0100 : 4'b0000);
      check("glitch_held", bus.held, (c >= 6 && c < 20) ? 4'b0100 : 4'b0000);
      cyc++;
    end

    // Reset during WAIT_PRESS with the button still high, then reset mid-pulse.
    do_reset(4'b0000, 1'b1);
    set_in(4'b0001, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step();
      check("pre_reset_push", get_push(), 4'b0000);
      cyc++;
    end
    reset = 1'b1;
    #1;
    check("async_reset_held", bus.held, 4'b0000);
    step();
    cyc++;
    check("no_pulse_at_6", get_push(), 4'b0000);
    step();
    cyc++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 8; c <= 14; c++) begin
      cyc = c;
      step();
      check("rerun_push", get_push(), (c == 14) ? 4'b0001 : 4'b0000);
      check("rerun_held", bus.held, (c == 14) ? 4'b0001 : 4'b0000);
    end
    reset = 1'b1;
    #1;
    check("reset_mid_pulse", get_push(), 4'b0000);
    check("reset_mid_held", bus.held, 4'b0000);
    step();
    reset = 1'b0;
    set_in(4'b0000, 1'b1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
